xbox_port_arbiter: RTL

- Shares the single TPUM xbox memory port (1024-bit data, 14-bit address) among NUM_REQ requesters, e.g. the three PUM engines plus the APB-driven loader.
- Round-robin grant with bounded bursts; registers commands onto the xbox port.
- Tracks in-flight reads with a tag pipeline and returns read data to the issuing requester.
- Sits between the triple_pum engines and the xbox memory.

---
 rtl/xbox_arb_pkg.sv | 16 +
 rtl/xbox_rd_tag_pipe.sv | 38 +++
 rtl/xbox_port_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/xbox_arb_pkg.sv
// rtl/xbox_arb_pkg.sv - shared types, widths and round-robin helper for the xbox port arbiter
package xbox_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int XBOX_ADDR_W = 14;
    localparam int XBOX_DATA_W = 1024;

    function automatic int next_rr(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/xbox_rd_tag_pipe.sv
// rtl/xbox_rd_tag_pipe.sv - fixed-latency {valid, id} shift register tracking in-flight xbox reads
module xbox_rd_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int ID_W  = 2
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic            pending
);

    logic [DEPTH-1:0] vld;
    logic [ID_W-1:0]  ids [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ids[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            ids[0] <= in_id;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                ids[i] <= ids[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_id    = ids[DEPTH-1];
    assign pending   = |vld;

endmodule

// File: rtl/xbox_port_arbiter.sv
// rtl/xbox_port_arbiter.sv - round-robin bounded-burst arbiter for the shared xbox memory port
// Optional per-requester beat counters: XBOX_ARB_STATS_EN
module xbox_port_arbiter
    import xbox_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = XBOX_ADDR_W,
    parameter int DATA_W    = XBOX_DATA_W,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      xbox_rd,
    output logic                      xbox_wr,
    output logic [ADDR_W-1:0]         xbox_addr,
    output logic [DATA_W-1:0]         xbox_wdata,
    input  logic [DATA_W-1:0]         xbox_rdata,
    output logic                      busy,
    output logic [NUM_REQ*32-1:0]     stat_beats
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BC_W = $clog2(MAX_BURST + 1);

    arb_state_e       state;
    logic [ID_W-1:0]  grant_q;
    logic [ID_W-1:0]  rr_ptr;
    logic [BC_W-1:0]  beat_cnt;
    logic [ID_W-1:0]  cmd_id;

    logic [ID_W-1:0]  pick;
    logic             any_valid;
    int               scan_idx;

    logic             accept;
    logic             cur_write;
    logic             cur_last;
    logic             burst_end;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;

    logic             tag_valid;
    logic [ID_W-1:0]  tag_id;
    logic             tag_pending;

    // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        pick      = rr_ptr;
        any_valid = 1'b0;
        scan_idx  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[scan_idx]) begin
                pick      = ID_W'(scan_idx);
                any_valid = 1'b1;
            end
        end
    end

    assign accept    = (state == OWN) && req_valid[grant_q];
    assign cur_write = req_write[grant_q];
    assign cur_last  = req_last[grant_q];
    assign cur_addr  = req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
    assign cur_wdata = req_wdata[int'(grant_q)*DATA_W +: DATA_W];
    assign burst_end = (beat_cnt == BC_W'(MAX_BURST - 1));

    assign req_ready = (state == OWN) ? (NUM_REQ'(1) << grant_q) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_q    <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            cmd_id     <= '0;
            xbox_rd    <= 1'b0;
            xbox_wr    <= 1'b0;
            xbox_addr  <= '0;
            xbox_wdata <= '0;
        end else begin
            xbox_rd <= accept && !cur_write;
            xbox_wr <= accept && cur_write;
            if (accept) begin
                xbox_addr  <= cur_addr;
                xbox_wdata <= cur_wdata;
                cmd_id     <= grant_q;
            end
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_q  <= pick;
                        beat_cnt <= '0;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    // An idle owner gives the port up so others are not starved.
                    if (!accept || cur_last || burst_end) begin
                        state    <= IDLE;
                        rr_ptr   <= ID_W'(next_rr(int'(grant_q), NUM_REQ));
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    xbox_rd_tag_pipe #(
        .DEPTH (RD_LAT),
        .ID_W  (ID_W)
    ) u_tag_pipe (
        .clk       (clk),
        .clr       (rst),
        .in_valid  (xbox_rd),
        .in_id     (cmd_id),
        .out_valid (tag_valid),
        .out_id    (tag_id),
        .pending   (tag_pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else if (tag_valid) begin
            rsp_valid <= NUM_REQ'(1) << tag_id;
            rsp_rdata <= xbox_rdata;
        end else begin
            rsp_valid <= '0;
        end
    end

    assign busy = (state == OWN) || xbox_rd || tag_pending;

`ifdef XBOX_ARB_STATS_EN
    logic [31:0] beat_ctr [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                beat_ctr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && (grant_q == ID_W'(i)) && (beat_ctr[i] != 32'hFFFF_FFFF)) begin
                    beat_ctr[i] <= beat_ctr[i] + 32'd1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        assign stat_beats[gi*32 +: 32] = beat_ctr[gi];
    end
`else
    assign stat_beats = '0;
`endif

endmodule
